// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the round-robin divider-sharing arbiter.
package div_arb_pkg;

  localparam int NREQ_D    = 4;
  localparam int W_D       = 4;
  localparam int TIMEOUT_D = 16;
  localparam int CNT_W     = $clog2(TIMEOUT_D + 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_g+1, with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_g,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  int   j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(last_g) + i) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one divider among NREQ requesters: capture, issue, watchdog wait, one-cycle response.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_D,
  parameter int W       = W_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] x_in,
  input  logic [NREQ*W-1:0] y_in,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      quot_out,
  output logic [W-1:0]      rem_out,
  output logic              err_dbz,
  output logic              err_tmo,
  output logic              busy,
  output logic              div_start,
  output logic [W-1:0]      div_x,
  output logic [W-1:0]      div_y,
  input  logic              div_valid,
  input  logic [W-1:0]      div_quot,
  input  logic [W-1:0]      div_rem
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_n;
  logic [IW-1:0]   g, last_g, pick_idx;
  logic [NREQ-1:0] g_oh, pick_oh;
  logic [W-1:0]    cap_x, cap_y, res_q, res_r;
  logic            dbz, tmo;
  logic [CW-1:0]   cnt;
  logic            accept, expire;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .last_g(last_g),
    .gnt   (pick_oh),
    .idx   (pick_idx)
  );

  // First WAIT cycle has cnt==0; a valid seen there may be left over from an aborted op.
  assign accept = (state == WAIT) && div_valid && (cnt != '0);
  assign expire = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|req) state_n = GRANT;
      GRANT:   state_n = (cap_y == '0) ? RESP : ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (accept || expire) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g      <= '0;
      g_oh   <= '0;
      last_g <= IW'(NREQ - 1);
      cap_x  <= '0;
      cap_y  <= '0;
      res_q  <= '0;
      res_r  <= '0;
      dbz    <= 1'b0;
      tmo    <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          g     <= pick_idx;
          g_oh  <= pick_oh;
          cap_x <= x_in[pick_idx*W +: W];
          cap_y <= y_in[pick_idx*W +: W];
        end
        GRANT: if (cap_y == '0) begin
          dbz   <= 1'b1;
          res_q <= '1;
          res_r <= cap_x;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          // Valid wins over a coincident timeout.
          if (accept) begin
            res_q <= div_quot;
            res_r <= div_rem;
          end else if (expire) begin
            tmo   <= 1'b1;
            res_q <= '0;
            res_r <= '0;
          end
        end
        RESP: begin
          last_g <= g;
          dbz    <= 1'b0;
          tmo    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ack       = (state == GRANT) ? g_oh : '0;
  assign done      = (state == RESP)  ? g_oh : '0;
  assign busy      = (state != IDLE);
  assign div_start = (state == ISSUE);
  assign div_x     = cap_x;
  assign div_y     = cap_y;
  assign quot_out  = res_q;
  assign rem_out   = res_r;
  assign err_dbz   = dbz;
  assign err_tmo   = tmo;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Randomized bench for div_share_arbiter against a transaction-level timing/result model.
module tb_div_share_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] x_in, y_in;
  logic [NREQ-1:0]   ack, done;
  logic [W-1:0]      quot_out, rem_out, div_x, div_y;
  logic              err_dbz, err_tmo, busy, div_start;
  logic              div_valid = 1'b0;
  logic [W-1:0]      div_quot, div_rem;

  int nchk = 0;
  int nerr = 0;
  int last_g;
  int dly = 0;

  div_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
    .ack(ack), .done(done), .quot_out(quot_out), .rem_out(rem_out),
    .err_dbz(err_dbz), .err_tmo(err_tmo), .busy(busy), .div_start(div_start),
    .div_x(div_x), .div_y(div_y), .div_valid(div_valid),
    .div_quot(div_quot), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  // Divider model: one-cycle valid pulse dly cycles after start (dly==0: never).
  logic [W-1:0] mq = '0, mr = '0;
  int tmr = 0;
  assign div_quot = mq;
  assign div_rem  = mr;

  always @(posedge clk) begin
    div_valid <= 1'b0;
    if (div_start) begin
      mq <= (div_y != 0) ? div_x / div_y : '1;
      mr <= (div_y != 0) ? div_x % div_y : div_x;
      if (dly == 1) div_valid <= 1'b1;
      tmr <= (dly > 1) ? dly - 1 : 0;
    end else if (tmr != 0) begin
      tmr <= tmr - 1;
      if (tmr == 1) div_valid <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_model(input logic [NREQ-1:0] p, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (p[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic raise(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    req[i] = 1'b1;
    x_in[i*W +: W] = x;
    y_in[i*W +: W] = y;
  endtask

  task automatic chk_all_zero();
    chk("z_ack", ack, 0);        chk("z_done", done, 0);
    chk("z_busy", busy, 0);      chk("z_start", div_start, 0);
    chk("z_dbz", err_dbz, 0);    chk("z_tmo", err_tmo, 0);
    chk("z_quot", quot_out, 0);  chk("z_rem", rem_out, 0);
    chk("z_divx", div_x, 0);     chk("z_divy", div_y, 0);
  endtask

  // Called while the DUT is in IDLE with req already driven; returns in the next IDLE cycle.
  task automatic serve(input int d);
    int g, off;
    logic [W-1:0] ex, ey, eq, er;
    logic edbz, etmo;
    logic [NREQ-1:0] oh, eack, edone;
    chk("idle_busy", busy, 0);
    g = rr_model(req, last_g);
    if (g < 0) begin
      chk("no_request", 0, 1);
      return;
    end
    oh = NREQ'(1) << g;
    ex = x_in[g*W +: W];
    ey = y_in[g*W +: W];
    dly  = d;
    edbz = (ey == 0);
    etmo = 1'b0;
    if (edbz) begin
      eq = '1; er = ex; off = 2;
    end else if (d >= 2 && d <= TIMEOUT) begin
      eq = ex / ey; er = ex % ey; off = 3 + d;
    end else begin
      eq = '0; er = '0; etmo = 1'b1; off = 3 + TIMEOUT;
    end
    for (int t = 1; t <= off; t++) begin
      @(posedge clk); #1;
      eack  = (t == 1)   ? oh : '0;
      edone = (t == off) ? oh : '0;
      chk("ack", ack, eack);
      chk("done", done, edone);
      chk("div_start", div_start, (!edbz && t == 2));
      chk("busy", busy, 1);
      if (t == 1) begin
        req[g] = 1'b0;
        x_in[g*W +: W] = W'($urandom);
        y_in[g*W +: W] = W'($urandom);
      end
      if (!edbz && t == 2) begin
        chk("div_x", div_x, ex);
        chk("div_y", div_y, ey);
      end
      if (t == off) begin
        chk("quot", quot_out, eq);
        chk("rem", rem_out, er);
        chk("err_dbz", err_dbz, edbz);
        chk("err_tmo", err_tmo, etmo);
      end
    end
    last_g = g;
    @(posedge clk); #1;
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; x_in = '0; y_in = '0; last_g = NREQ - 1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero();
    rst = 1'b0;
    @(posedge clk); #1;

    // single request 15/8
    raise(0, 4'd15, 4'd8);
    serve(5);

    // contention: 1 before 3
    raise(1, 4'd10, 4'd2);
    raise(3, 4'd9, 4'd4);
    serve(5);
    chk("cont_last1", last_g, 1);
    serve(5);
    chk("cont_last3", last_g, 3);

    // round-robin wrap with all four continuously requesting
    for (int i = 0; i < NREQ; i++) raise(i, W'($urandom), W'($urandom_range(1, 15)));
    for (int n = 0; n < 8; n++) begin
      serve(5);
      chk("wrap_order", last_g, n % NREQ);
      raise(last_g, W'($urandom), W'($urandom_range(1, 15)));
    end
    req = '0;

    // divide by zero
    raise(2, 4'd6, 4'd0);
    serve(5);

    // timeout, stale-valid guard, and valid coinciding with timeout
    raise(0, 4'd7, 4'd3); serve(0);
    raise(1, 4'd7, 4'd3); serve(1);
    raise(2, 4'd13, 4'd5); serve(TIMEOUT);
    raise(3, 4'd13, 4'd5); serve(2);

    // reset during WAIT: no done, late valid discarded
    raise(0, 4'd9, 4'd3);
    dly = 5;
    repeat (4) begin
      @(posedge clk); #1;
      req = '0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero();
    rst = 1'b0;
    last_g = NREQ - 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    raise(1, 4'd14, 4'd4);
    serve(3);

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 1) == 1) raise(i, W'($urandom), W'($urandom));
      if (req == 0) raise(int'($urandom_range(0, NREQ - 1)), W'($urandom), W'($urandom));
      serve(int'($urandom_range(0, TIMEOUT + 1)));
    end
    req = '0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
